// File: rtl/cpu_pkg.sv
// Shared CPU-side constants for the memory-mapped interval timer: window base,
// register offsets, TCON bit positions and the address-to-register decode.
package cpu_pkg;

  localparam logic [31:0] TIMER_BASE = 32'h4000_0000;

  localparam logic [3:0] TH_OFF   = 4'h0;
  localparam logic [3:0] TL_OFF   = 4'h4;
  localparam logic [3:0] TCON_OFF = 4'h8;

  localparam int TCON_EN = 0;  // run enable
  localparam int TCON_IE = 1;  // irq enable
  localparam int TCON_ST = 2;  // irq status, sticky

  typedef enum logic [1:0] {
    REG_TH,
    REG_TL,
    REG_TCON,
    REG_NONE
  } reg_sel_e;

  // Offset is the byte address minus the window base; anything outside the
  // three aligned words maps to REG_NONE.
  function automatic reg_sel_e reg_decode(input logic [31:0] offset);
    reg_sel_e sel;
    sel = REG_NONE;
    if (offset[31:4] == 28'd0 && offset[1:0] == 2'b00) begin
      case (offset[3:0])
        TH_OFF:   sel = REG_TH;
        TL_OFF:   sel = REG_TL;
        TCON_OFF: sel = REG_TCON;
        default:  sel = REG_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/timer_irq_source_if.sv
// CPU data-bus view of the timer: address/strobes from the core, read data and
// window hit back to the core's load mux.
interface timer_irq_source_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] rdata;
  logic        hit;

  modport master (output addr, wdata, MemRead, MemWrite, input rdata, hit);
  modport slave  (input addr, wdata, MemRead, MemWrite, output rdata, hit);
endinterface

// File: rtl/timer_prescaler.sv
// Divides clk by (presc_i+1) while enabled; tick_o is high in the cycle the
// count matches, and the count is held whenever the timer is stopped.
module timer_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] pcnt_q, pcnt_d;

  assign tick_o = en_i && (pcnt_q == presc_i);

  // NOTE: default the next-state value before any condition so no path leaves
  // it unassigned; otherwise always_comb infers a latch.
  always_comb begin
    pcnt_d = pcnt_q;
    if (en_i) begin
      pcnt_d = tick_o ? '0 : pcnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // values from before the edge, independent of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/timer_irq_source.sv
// Memory-mapped interval timer (TH reload, TL count, TCON ctrl/status) that
// raises a level IRQ on TL overflow until software clears the status bit.
module timer_irq_source
  import cpu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = TIMER_BASE,
  parameter int          PRESC_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  timer_irq_source_if.slave  bus,
  input  logic [PRESC_W-1:0] presc,
  output logic               IRQ
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;

  reg_sel_e    sel;
  logic [31:0] offset;
  logic        we_th, we_tl, we_tcon;
  logic        tick, overflow, status_set;

  assign offset   = bus.addr - BASE_ADDR;
  assign sel      = reg_decode(offset);
  assign bus.hit  = (sel != REG_NONE);

  assign we_th    = bus.MemWrite && (sel == REG_TH);
  assign we_tl    = bus.MemWrite && (sel == REG_TL);
  assign we_tcon  = bus.MemWrite && (sel == REG_TCON);

  timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk     (clk),
    .reset   (reset),
    .en_i    (tcon_q[TCON_EN]),
    .presc_i (presc),
    .tick_o  (tick)
  );

  assign overflow   = tick && (tl_q == 32'hFFFF_FFFF);
  assign status_set = overflow && tcon_q[TCON_IE];

  // Bus writes override the count, but the overflow's status set is applied
  // after a TCON write so a clear racing an overflow never loses the IRQ.
  always_comb begin
    th_d   = we_th ? bus.wdata : th_q;
    tl_d   = tl_q;
    tcon_d = we_tcon ? bus.wdata[2:0] : tcon_q;
    if (tick) begin
      tl_d = overflow ? th_q : tl_q + 32'd1;
    end
    if (we_tl) begin
      tl_d = bus.wdata;
    end
    if (status_set) begin
      tcon_d[TCON_ST] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.MemRead) begin
      case (sel)
        REG_TH:   bus.rdata = th_q;
        REG_TL:   bus.rdata = tl_q;
        REG_TCON: bus.rdata = {29'd0, tcon_q};
        default:  bus.rdata = '0;
      endcase
    end
  end

  // Driven only from register state, so bus inputs never reach the IRQ line.
  assign IRQ = tcon_q[TCON_IE] & tcon_q[TCON_ST];

endmodule
